// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-Lite arbiter (m0 read-only IFU, m1 read/write LSU) onto one slave; ARB_RR_EN enables m0/m1 read round-robin.
// Latency: one registered arbitration cycle before a grant, then a combinational pass-through until the response handshake.
// Backpressure: channels pass straight through while granted; ungranted masters see ready=0 and valid=0.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [1:0]          owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RD_M0 = 2'b01,
        RD_M1 = 2'b10,
        WR    = 2'b11
    } state_t;

    state_t r_state;
    logic   r_ar_done;
    logic   r_aw_done;
    logic   r_w_done;

    logic w_rd_m0;
    logic w_rd_m1;
    logic w_wr;
    logic w_wr_resp_ok;
    logic w_pick_m1;

    assign w_rd_m0      = (r_state == RD_M0);
    assign w_rd_m1      = (r_state == RD_M1);
    assign w_wr         = (r_state == WR);
    assign w_wr_resp_ok = w_wr && r_aw_done && r_w_done;

`ifdef ARB_RR_EN
    // Pointer holds the last master served; a write counts as m1 being served.
    logic r_last_m1;

    assign w_pick_m1 = m1_arvalid && (!m0_arvalid || !r_last_m1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_m1 <= 1'b0;
        end else if (r_state == IDLE) begin
            if (m1_awvalid || w_pick_m1) begin
                r_last_m1 <= 1'b1;
            end else if (m0_arvalid) begin
                r_last_m1 <= 1'b0;
            end
        end
    end
`else
    assign w_pick_m1 = m1_arvalid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ar_done <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (m1_awvalid) begin
                        r_state <= WR;
                    end else if (w_pick_m1) begin
                        r_state <= RD_M1;
                    end else if (m0_arvalid) begin
                        r_state <= RD_M0;
                    end
                end
                RD_M0, RD_M1: begin
                    if (s_arvalid && s_arready) begin
                        r_ar_done <= 1'b1;
                    end
                    if (s_rvalid && s_rready) begin
                        r_state <= IDLE;
                    end
                end
                WR: begin
                    if (s_awvalid && s_awready) begin
                        r_aw_done <= 1'b1;
                    end
                    if (s_wvalid && s_wready) begin
                        r_w_done <= 1'b1;
                    end
                    if (s_bvalid && s_bready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign owner = r_state;

    // Read address: the done flag keeps a second AR from leaking while the master still holds valid.
    assign s_araddr   = w_rd_m1 ? m1_araddr : m0_araddr;
    assign s_arvalid  = !r_ar_done && ((w_rd_m0 && m0_arvalid) || (w_rd_m1 && m1_arvalid));
    assign m0_arready = w_rd_m0 && !r_ar_done && s_arready;
    assign m1_arready = w_rd_m1 && !r_ar_done && s_arready;

    // R is only routed once the AR has gone out, so a stale response cannot reach a new owner.
    assign m0_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rdata  = s_rdata;
    assign m1_rresp  = s_rresp;
    assign m0_rvalid = w_rd_m0 && r_ar_done && s_rvalid;
    assign m1_rvalid = w_rd_m1 && r_ar_done && s_rvalid;
    assign s_rready  = r_ar_done && ((w_rd_m0 && m0_rready) || (w_rd_m1 && m1_rready));

    assign s_awaddr   = m1_awaddr;
    assign s_awvalid  = w_wr && !r_aw_done && m1_awvalid;
    assign m1_awready = w_wr && !r_aw_done && s_awready;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wvalid   = w_wr && !r_w_done && m1_wvalid;
    assign m1_wready  = w_wr && !r_w_done && s_wready;

    assign m1_bresp  = s_bresp;
    assign m1_bvalid = w_wr_resp_ok && s_bvalid;
    assign s_bready  = w_wr_resp_ok && m1_bready;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: reads, arbitration order, split AW/W write, stalls and reset abort.
// Inputs change 1ns after the rising edge; handshakes are tallied on the falling edge.
module tb_axi_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, s_araddr, s_awaddr;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [63:0] m0_rdata, m1_rdata, m1_wdata, s_rdata, s_wdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp, owner;
    logic [7:0]  m1_wstrb, s_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bvalid, s_bready;

    int vectors = 0;
    int miscompares = 0;
    int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Inputs are stable from +1ns to the next rising edge, so the falling edge sees the handshake state.
    always @(negedge clk) begin
        if (s_arvalid && s_arready) n_ar++;
        if (s_awvalid && s_awready) n_aw++;
        if (s_wvalid && s_wready)   n_w++;
        if (s_bvalid && s_bready)   n_b++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Precondition: the grant to master m was taken on the last edge and its arvalid is still high.
    task automatic serve_read(input logic m, input logic [31:0] addr, input logic [63:0] data, input int delay);
        logic [1:0] exp_own;
        exp_own = m ? 2'b10 : 2'b01;
        #1;
        vectors++; if (owner !== exp_own) begin miscompares++; $display("FAIL rd_owner m%0d got=%b exp=%b", m, owner, exp_own); end
        vectors++; if (s_arvalid !== 1'b1 || s_araddr !== addr) begin miscompares++; $display("FAIL rd_s_ar m%0d got valid=%b addr=%h exp valid=1 addr=%h", m, s_arvalid, s_araddr, addr); end
        vectors++; if ((m ? m1_arready : m0_arready) !== 1'b1 || (m ? m0_arready : m1_arready) !== 1'b0) begin miscompares++; $display("FAIL rd_arready m%0d got m0=%b m1=%b exp only granted=1", m, m0_arready, m1_arready); end
        tick;
        vectors++; if (s_arvalid !== 1'b0 || (m ? m1_arready : m0_arready) !== 1'b0) begin miscompares++; $display("FAIL rd_ar_done m%0d got s_arvalid=%b arready=%b exp 0/0", m, s_arvalid, m ? m1_arready : m0_arready); end
        if (m) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        repeat (delay) tick;
        s_rdata = data; s_rresp = 2'b00; s_rvalid = 1'b1;
        #1;
        vectors++; if ((m ? m1_rvalid : m0_rvalid) !== 1'b1 || (m ? m1_rdata : m0_rdata) !== data || (m ? m1_rresp : m0_rresp) !== 2'b00) begin miscompares++; $display("FAIL rd_r m%0d got valid=%b data=%h resp=%b exp 1/%h/00", m, m ? m1_rvalid : m0_rvalid, m ? m1_rdata : m0_rdata, m ? m1_rresp : m0_rresp, data); end
        vectors++; if ((m ? m0_rvalid : m1_rvalid) !== 1'b0 || s_rready !== 1'b1) begin miscompares++; $display("FAIL rd_r_route m%0d got other_rvalid=%b s_rready=%b exp 0/1", m, m ? m0_rvalid : m1_rvalid, s_rready); end
        tick;
        vectors++; if (owner !== 2'b00 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_to_idle m%0d got owner=%b rvalid=%b%b exp 00/00", m, owner, m0_rvalid, m1_rvalid); end
        s_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        m0_araddr = '0; m1_araddr = '0; m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0;
        m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rdata = '0; s_rresp = '0; s_rvalid = 1'b1; s_bresp = '0; s_bvalid = 1'b1;
        #3;
        vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL reset_owner got=%b exp=00", owner); end
        vectors++; if ({s_arvalid, s_awvalid, s_wvalid, m0_rvalid, m1_rvalid, m1_bvalid} !== 6'b0) begin miscompares++; $display("FAIL reset_valids got=%b exp=000000", {s_arvalid, s_awvalid, s_wvalid, m0_rvalid, m1_rvalid, m1_bvalid}); end
        vectors++; if ({m0_arready, m1_arready, m1_awready, m1_wready, s_rready, s_bready} !== 6'b0) begin miscompares++; $display("FAIL reset_readies got=%b exp=000000", {m0_arready, m1_arready, m1_awready, m1_wready, s_rready, s_bready}); end
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL reset_held_owner got=%b exp=00", owner); end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        s_rvalid = 1'b0; s_bvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick;
        vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL reset_idle_owner got=%b exp=00", owner); end
    endtask

    task automatic test_m0_read;
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; s_arready = 1'b1;
        #1;
        vectors++; if (owner !== 2'b00 || m0_arready !== 1'b0 || s_arvalid !== 1'b0) begin miscompares++; $display("FAIL idle_no_accept got owner=%b m0_arready=%b s_arvalid=%b exp 00/0/0", owner, m0_arready, s_arvalid); end
        tick;
        serve_read(1'b0, 32'h8000_0000, 64'h13, 2);
    endtask

    task automatic test_two_reads;
        m0_araddr = 32'h0000_0100; m0_arvalid = 1'b1;
        m1_araddr = 32'h0000_0200; m1_arvalid = 1'b1;
        tick;
        serve_read(1'b1, 32'h0000_0200, 64'h22, 1);
        vectors++; if (m0_arready !== 1'b0 || owner !== 2'b00) begin miscompares++; $display("FAIL pair_bubble got m0_arready=%b owner=%b exp 0/00", m0_arready, owner); end
        tick;
        serve_read(1'b0, 32'h0000_0100, 64'h33, 0);
    endtask

    task automatic test_round_robin;
        m1_araddr = 32'h0000_0300; m1_arvalid = 1'b1;
        tick;
        serve_read(1'b1, 32'h0000_0300, 64'h44, 0);
        m0_araddr = 32'h0000_0400; m0_arvalid = 1'b1;
        m1_araddr = 32'h0000_0500; m1_arvalid = 1'b1;
        tick;
`ifdef ARB_RR_EN
        serve_read(1'b0, 32'h0000_0400, 64'h55, 0);
        tick;
        serve_read(1'b1, 32'h0000_0500, 64'h66, 0);
`else
        serve_read(1'b1, 32'h0000_0500, 64'h66, 0);
        tick;
        serve_read(1'b0, 32'h0000_0400, 64'h55, 0);
`endif
    endtask

    task automatic test_ar_stall;
        int base;
        base = n_ar;
        m0_araddr = 32'h4000_0040; m0_arvalid = 1'b1; s_arready = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h4000_0040 || m0_arready !== 1'b0) begin miscompares++; $display("FAIL ar_stall cyc%0d got valid=%b addr=%h arready=%b exp 1/40000040/0", i, s_arvalid, s_araddr, m0_arready); end
            tick;
        end
        s_arready = 1'b1;
        serve_read(1'b0, 32'h4000_0040, 64'h77, 1);
        vectors++; if (n_ar - base !== 1) begin miscompares++; $display("FAIL ar_stall_count got=%0d exp=1", n_ar - base); end
    endtask

    task automatic test_write;
        int b_aw, b_w, b_b;
        b_aw = n_aw; b_w = n_w; b_b = n_b;
        m1_awaddr = 32'h8000_1000; m1_awvalid = 1'b1;
        m1_wdata = 64'hDEAD_BEEF; m1_wstrb = 8'h0F; m1_wvalid = 1'b1;
        s_awready = 1'b0; s_wready = 1'b1; s_bresp = 2'b01;
        tick;
        vectors++; if (owner !== 2'b11 || s_awvalid !== 1'b1 || s_awaddr !== 32'h8000_1000) begin miscompares++; $display("FAIL wr_aw got owner=%b valid=%b addr=%h exp 11/1/80001000", owner, s_awvalid, s_awaddr); end
        vectors++; if (s_wvalid !== 1'b1 || s_wdata !== 64'hDEAD_BEEF || s_wstrb !== 8'h0F || m1_wready !== 1'b1) begin miscompares++; $display("FAIL wr_w got valid=%b data=%h strb=%h wready=%b exp 1/deadbeef/0f/1", s_wvalid, s_wdata, s_wstrb, m1_wready); end
        tick;
        vectors++; if (s_wvalid !== 1'b0 || m1_wready !== 1'b0 || owner !== 2'b11) begin miscompares++; $display("FAIL wr_w_done got s_wvalid=%b wready=%b owner=%b exp 0/0/11", s_wvalid, m1_wready, owner); end
        m1_wvalid = 1'b0; s_bvalid = 1'b1;
        #1;
        vectors++; if (m1_bvalid !== 1'b0 || s_bready !== 1'b0) begin miscompares++; $display("FAIL wr_b_early got bvalid=%b bready=%b exp 0/0", m1_bvalid, s_bready); end
        tick;
        s_awready = 1'b1;
        tick;
        vectors++; if (s_awvalid !== 1'b0 || m1_awready !== 1'b0 || owner !== 2'b11) begin miscompares++; $display("FAIL wr_aw_done got s_awvalid=%b awready=%b owner=%b exp 0/0/11", s_awvalid, m1_awready, owner); end
        m1_awvalid = 1'b0;
        #1;
        vectors++; if (m1_bvalid !== 1'b1 || m1_bresp !== 2'b01 || s_bready !== 1'b1) begin miscompares++; $display("FAIL wr_b got bvalid=%b bresp=%b bready=%b exp 1/01/1", m1_bvalid, m1_bresp, s_bready); end
        tick;
        vectors++; if (owner !== 2'b00 || m1_bvalid !== 1'b0) begin miscompares++; $display("FAIL wr_to_idle got owner=%b bvalid=%b exp 00/0", owner, m1_bvalid); end
        s_bvalid = 1'b0;
        vectors++; if (n_aw - b_aw !== 1 || n_w - b_w !== 1 || n_b - b_b !== 1) begin miscompares++; $display("FAIL wr_counts got aw=%0d w=%0d b=%0d exp 1/1/1", n_aw - b_aw, n_w - b_w, n_b - b_b); end
    endtask

    task automatic test_wr_vs_rd;
        m1_awaddr = 32'h0000_0600; m1_awvalid = 1'b1; m1_wdata = 64'h1; m1_wstrb = 8'hFF; m1_wvalid = 1'b1;
        m1_araddr = 32'h0000_0700; m1_arvalid = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1; s_bresp = 2'b00;
        tick;
        vectors++; if (owner !== 2'b11 || m0_arready !== 1'b0 || m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin miscompares++; $display("FAIL wr_first got owner=%b m0_arready=%b m1_arready=%b s_arvalid=%b exp 11/0/0/0", owner, m0_arready, m1_arready, s_arvalid); end
        tick;
        m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_bvalid = 1'b1;
        #1;
        vectors++; if (m1_bvalid !== 1'b1 || m0_arready !== 1'b0) begin miscompares++; $display("FAIL wr_both_b got bvalid=%b m0_arready=%b exp 1/0", m1_bvalid, m0_arready); end
        tick;
        s_bvalid = 1'b0;
        tick;
        serve_read(1'b1, 32'h0000_0700, 64'h88, 1);
    endtask

    task automatic test_reset_mid;
        m0_araddr = 32'h0000_0800; m0_arvalid = 1'b1; s_arready = 1'b1;
        tick;
        tick;
        m0_arvalid = 1'b0;
        tick;
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (owner !== 2'b00 || {s_arvalid, s_awvalid, s_wvalid, m0_rvalid, m1_rvalid, m1_bvalid} !== 6'b0) begin miscompares++; $display("FAIL mid_reset got owner=%b valids=%b exp 00/000000", owner, {s_arvalid, s_awvalid, s_wvalid, m0_rvalid, m1_rvalid, m1_bvalid}); end
        vectors++; if (s_rready !== 1'b0 || m0_arready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ready got s_rready=%b m0_arready=%b exp 0/0", s_rready, m0_arready); end
        @(negedge clk);
        rst = 1'b1;
        tick;
        s_rdata = 64'h99; s_rvalid = 1'b1;
        #1;
        vectors++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || owner !== 2'b00) begin miscompares++; $display("FAIL late_r got rvalid=%b%b owner=%b exp 00/00", m0_rvalid, m1_rvalid, owner); end
        tick;
        vectors++; if (m0_rvalid !== 1'b0 || owner !== 2'b00) begin miscompares++; $display("FAIL late_r_hold got rvalid=%b owner=%b exp 0/00", m0_rvalid, owner); end
        s_rvalid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_m0_read;
        test_two_reads;
        test_round_robin;
        test_ar_stall;
        test_write;
        test_wr_vs_rd;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
